// File: rtl/sh_sync_pkg.sv
// ---------------------------------------------------------------------------
// sh_sync_pkg
// Shared types and default timing constants for the OOK bit-slot timing
// generator (sh_sync) and its input conditioning.
// ---------------------------------------------------------------------------
package sh_sync_pkg;

  // Operating state of the slot timer.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX_ACQ   = 2'd1,
    RX_TRACK = 2'd2,
    TX       = 2'd3
  } state_t;

  // Defaults for a 10 MHz clock and a 1 ms bit slot.
  localparam int CLK_PER_BIT = 10000;  // clocks per bit slot
  localparam int SAMPLE_CNT  = 5000;   // slot-counter value of the receive strobe

endpackage : sh_sync_pkg

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer for an asynchronous input followed by an edge
// register; flags a rising edge of the synchronized signal for one cycle.
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous active-low reset
//   din   in  1  asynchronous input
//   rise  out 1  high for one cycle when the synchronized input goes 0->1
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic edge_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; a blocking chain here
  // would collapse the synchronizer into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q1 <= din;      // may go metastable; never used outside this chain
      sync_q2 <= sync_q1;
      edge_q  <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~edge_q;

endmodule : sync_edge_det

// File: rtl/sh_sync.sv
// ---------------------------------------------------------------------------
// sh_sync
// Bit-slot timing generator for the OOK shift path. In receive mode the slot
// phase is recovered from rfin pulses and sh_en fires at the sample point of
// every slot; in transmit mode the slot timer free-runs and sh_en fires on
// every slot wrap.
//
// Parameters:
//   CLK_PER_BIT  clocks per bit slot
//   SAMPLE_CNT   counter value (from the aligning edge) of the receive strobe
//   CNT_W        slot-counter width, must hold CLK_PER_BIT-1
//
// Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-low reset
//   rfin    in  1  asynchronous RF pulse input
//   RX      in  1  receive-mode select (highest priority)
//   tx_rdy  in  1  transmit-mode request, honoured while RX=0
//   sh_en   out 1  registered single-cycle shift strobe
// ---------------------------------------------------------------------------
module sh_sync #(
  parameter int CLK_PER_BIT = sh_sync_pkg::CLK_PER_BIT,
  parameter int SAMPLE_CNT  = sh_sync_pkg::SAMPLE_CNT,
  parameter int CNT_W       = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic rfin,
  input  logic RX,
  input  logic tx_rdy,
  output logic sh_en
);

  import sh_sync_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_CNT);

  state_t           state;
  state_t           mode_req;
  logic             mode_chg;
  logic [CNT_W-1:0] cnt;
  logic             seen;   // a realigning edge was taken in the current slot
  logic             rise;

  sync_edge_det u_sync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .din  (rfin),
    .rise (rise)
  );

  // Requested mode from the select inputs. Both receive states map onto
  // themselves so that the ACQ->TRACK step is not seen as a mode change.
  // NOTE: every branch assigns mode_req; a missing path in a combinational
  // block would infer a latch.
  always_comb begin
    if (RX) begin
      mode_req = (state == RX_ACQ || state == RX_TRACK) ? state : RX_ACQ;
    end else if (tx_rdy) begin
      mode_req = TX;
    end else begin
      mode_req = IDLE;
    end
  end

  assign mode_chg = (mode_req != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      seen  <= 1'b0;
      sh_en <= 1'b0;
    end else begin
      sh_en <= 1'b0;
      if (mode_chg) begin
        // Any mode switch discards the slot phase; no strobe this cycle.
        state <= mode_req;
        cnt   <= '0;
        seen  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
          end
          RX_ACQ: begin
            // Counter stays at 0 until the first pulse fixes the phase.
            if (rise) begin
              cnt   <= '0;
              seen  <= 1'b1;
              state <= RX_TRACK;
            end
          end
          RX_TRACK: begin
            if (rise && !seen) begin
              // Realignment takes precedence over a coincident sample point.
              cnt  <= '0;
              seen <= 1'b1;
            end else begin
              cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
              if (cnt == CNT_SAMPLE) begin
                sh_en <= 1'b1;
                seen  <= 1'b0;
              end
            end
          end
          TX: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              sh_en <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule : sh_sync

// File: tb/tb_sh_sync.sv
// ---------------------------------------------------------------------------
// tb_sh_sync
// Self-checking bench for sh_sync with a shortened slot (400 clocks, sample
// point 200). An event-scheduling reference model predicts sh_en every cycle
// from the pulse history and the selected mode; directed steps add
// strobe-count and strobe-position checks per scenario.
// ---------------------------------------------------------------------------
module tb_sh_sync;

  localparam int CPB = 400;
  localparam int S   = 200;
  localparam int W   = 9;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic rfin   = 1'b0;
  logic rx     = 1'b0;
  logic tx_rdy = 1'b0;
  logic sh_en;

  always #5 clk = ~clk;

  sh_sync #(
    .CLK_PER_BIT (CPB),
    .SAMPLE_CNT  (S),
    .CNT_W       (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rfin   (rfin),
    .RX     (rx),
    .tx_rdy (tx_rdy),
    .sh_en  (sh_en)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- stimulus schedule and reference model ----------------
  typedef enum {M_IDLE, M_RX, M_TX} mode_t;

  bit    rf_sched[int];     // cycles at which rfin is high at the clock edge
  int    cyc = 0;           // index of the most recent rising clock edge
  int    strobes[$];        // edges after which sh_en was observed high
  bit    r1, r2, r3;        // rfin as sampled 1, 2, 3 edges ago
  mode_t m_prev = M_IDLE;
  bit    acq, seen;
  int    next_strobe;
  logic  exp_en = 1'b0;

  task automatic add_pulse(input int t, input int w);
    for (int i = 0; i < w; i++) rf_sched[t + i] = 1'b1;
  endtask

  // One clock edge: advance the model, compare, then drive rfin for the next edge.
  task automatic tick();
    bit    rise_now;
    mode_t m_now;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      r1 = 0; r2 = 0; r3 = 0;
      m_prev = M_IDLE; acq = 0; seen = 0; exp_en = 1'b0;
    end else begin
      // A pulse sampled at edge T becomes visible to the timer at edge T+2.
      rise_now = r2 & ~r3;
      r3 = r2; r2 = r1; r1 = rfin;
      m_now  = rx ? M_RX : (tx_rdy ? M_TX : M_IDLE);
      exp_en = 1'b0;
      if (m_now != m_prev) begin
        acq  = (m_now == M_RX);
        seen = 0;
        if (m_now == M_TX) next_strobe = cyc + CPB;
      end else if (m_now == M_RX) begin
        if (acq) begin
          if (rise_now) begin
            acq = 0; seen = 1; next_strobe = cyc + 1 + S;
          end
        end else if (rise_now && !seen) begin
          seen = 1; next_strobe = cyc + 1 + S;
        end else if (cyc == next_strobe) begin
          exp_en = 1'b1; seen = 0; next_strobe += CPB;
        end
      end else if (m_now == M_TX && cyc == next_strobe) begin
        exp_en = 1'b1; next_strobe += CPB;
      end
      m_prev = m_now;
    end
    #1;
    check_bit("sh_en_cycle", sh_en, exp_en);
    if (sh_en === 1'b1) strobes.push_back(cyc);
    rfin = rf_sched.exists(cyc + 1);
  endtask

  function automatic int strobe_at(input int k);
    return (k < strobes.size()) ? strobes[k] : -1;
  endfunction

  // ------------------------------ directed steps ------------------------------
  initial begin
    int entry;
    int t1;
    int fs;
    int n;

    // Reset held with RX=1 and rfin toggling: no strobes at all.
    for (int i = 1; i <= 24; i++) if (i % 2 == 1) rf_sched[i] = 1'b1;
    rst = 1'b0; rx = 1'b1;
    repeat (24) tick();
    rst = 1'b1;
    strobes.delete();
    repeat (300) tick();
    check_int("no_strobe_after_reset", strobes.size(), 0);

    // Acquire: single pulse 100 cycles into receive mode.
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    entry = cyc + 1;
    add_pulse(entry + 100, 1);
    strobes.delete();
    while (cyc < entry + 100 + 3 + S + CPB + 50) tick();
    check_int("acq_count", strobes.size(), 2);
    check_int("acq_first", strobe_at(0), entry + 100 + 3 + S);
    check_int("acq_second", strobe_at(1), entry + 100 + 3 + S + CPB);

    // Glitch: second pulse inside the same slot must not realign.
    t1 = cyc + 150;
    add_pulse(t1, 1);
    add_pulse(t1 + 40, 2);
    strobes.delete();
    while (cyc < t1 + CPB) tick();
    check_int("glitch_count", strobes.size(), 1);
    check_int("glitch_pos", strobe_at(0), t1 + 3 + S);

    // Frame: 73 slots, pulse near slot start with jitter, random '0' slots.
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    entry = cyc + 1;
    fs = entry + 20;
    for (int k = 0; k < 73; k++) begin
      if (k == 0 || $urandom_range(0, 1) == 1)
        add_pulse(fs + k * CPB + int'($urandom_range(0, 40)), int'($urandom_range(1, 3)));
    end
    strobes.delete();
    while (cyc < fs + 73 * CPB) tick();
    check_int("frame_count", strobes.size(), 73);
    for (int k = 0; k < strobes.size() && k < 73; k++)
      check_int("frame_slot", (strobes[k] - fs) / CPB, k);

    // TX: 10 strobes exactly CPB apart, first CPB after entry.
    rx = 1'b0; tx_rdy = 1'b1;
    entry = cyc + 1;
    strobes.delete();
    while (cyc < entry + 10 * CPB) tick();
    check_int("tx_count", strobes.size(), 10);
    for (int k = 0; k < strobes.size() && k < 10; k++)
      check_int("tx_pos", strobes[k], entry + (k + 1) * CPB);

    // Mode change: leave receive mid-slot, then restart TX timing.
    tx_rdy = 1'b0; rx = 1'b1;
    entry = cyc + 1;
    add_pulse(entry + 30, 1);
    while (cyc < entry + 30 + 3 + S - 50) tick();
    rx = 1'b0;
    strobes.delete();
    repeat (2 * CPB) tick();
    check_int("idle_no_strobe", strobes.size(), 0);
    tx_rdy = 1'b1;
    entry = cyc + 1;
    strobes.delete();
    while (cyc < entry + CPB + 5) tick();
    check_int("tx_restart_count", strobes.size(), 1);
    check_int("tx_restart_pos", strobe_at(0), entry + CPB);

    // Asynchronous reset while the strobe is high clears it immediately.
    n = 0;
    while (sh_en !== 1'b1 && n < CPB + 5) begin
      tick();
      n++;
    end
    check_bit("strobe_before_rst", sh_en, 1'b1);
    rst = 1'b0;
    #1;
    check_bit("async_rst_clears", sh_en, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    entry = cyc + 1;
    strobes.delete();
    while (cyc < entry + CPB + 5) tick();
    check_int("post_rst_tx_count", strobes.size(), 1);
    check_int("post_rst_tx_pos", strobe_at(0), entry + CPB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sh_sync
